// File: rtl/sdram_arbiter.sv
// Three-way arbiter (instruction fetch, CPU data, DMA) in front of one SDRAM controller port.
// Optional transaction watchdog: define ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int STARVE_MAX     = 8,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [22:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [22:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    input  logic        x_req,
    input  logic        x_we,
    input  logic [22:0] x_addr,
    input  logic [15:0] x_wdata,
    output logic [15:0] x_rdata,
    output logic        x_ready,
    output logic [22:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        m_read_req,
    output logic        m_write_req,
    output logic        m_instruction_mode,
    input  logic        m_busy,
    input  logic        m_cack,
    input  logic        m_read_ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, GUARD} state_t;
    typedef enum logic [1:0] {P_I = 2'd0, P_D = 2'd1, P_X = 2'd2} port_t;

    state_t      state_q, state_d;
    port_t       port_q, port_d, sel_port;
    logic [22:0] addr_q, addr_d, sel_addr;
    logic [15:0] wdata_q, wdata_d, sel_wdata;
    logic        we_q, we_d, sel_we;
    logic        inst_q, inst_d;
    logic [7:0]  starve_q, starve_d;
    logic [3:0]  guard_q, guard_d;
    logic [2:0]  rdy_q, rdy_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic [15:0] x_rdata_q, x_rdata_d;
    logic        req_any, x_first;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    assign req_any = i_req | d_rd_req | d_wr_req | x_req;
    assign x_first = x_req && (starve_q == 8'(STARVE_MAX));

    // Starved DMA jumps the queue; otherwise D > I > X.
    always_comb begin
        sel_port  = P_X;
        sel_addr  = x_addr;
        sel_wdata = x_wdata;
        sel_we    = x_we;
        if (!x_first && (d_rd_req || d_wr_req)) begin
            sel_port  = P_D;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_we    = d_wr_req && !d_rd_req;
        end else if (!x_first && i_req) begin
            sel_port  = P_I;
            sel_addr  = i_addr;
            sel_wdata = 16'h0;
            sel_we    = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        inst_d    = inst_q;
        starve_d  = starve_q;
        guard_d   = guard_q;
        rdy_d     = 3'b000;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        x_rdata_d = x_rdata_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!x_req) starve_d = 8'd0;
                if (!m_busy && req_any) begin
                    port_d  = sel_port;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    inst_d  = (sel_port == P_I);
                    state_d = REQ;
`ifdef ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    if (sel_port == P_X)
                        starve_d = 8'd0;
                    else if (x_req && starve_q < 8'(STARVE_MAX))
                        starve_d = starve_q + 8'd1;
                end
            end
            REQ: begin
                if (m_cack) begin
                    if (we_q) begin
                        rdy_d[port_q] = 1'b1;
                        state_d       = GUARD;
                        guard_d       = 4'd0;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (m_read_ready) begin
                    case (port_q)
                        P_I:     i_rdata_d = m_rdata;
                        P_D:     d_rdata_d = m_rdata[15:0];
                        default: x_rdata_d = m_rdata[15:0];
                    endcase
                    rdy_d[port_q] = 1'b1;
                    state_d       = GUARD;
                    guard_d       = 4'd0;
                end
            end
            default: begin
                if (guard_q == 4'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                    inst_d  = 1'b0;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
        endcase
`ifdef ARB_TIMEOUT_EN
        // One budget spans both REQ and WAIT_DONE; a completion in the same cycle wins.
        if (state_q == REQ || state_q == WAIT_DONE) begin
            if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
            if (state_d == state_q && tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                err_d         = 1'b1;
                rdy_d[port_q] = 1'b1;
                state_d       = GUARD;
                guard_d       = 4'd0;
                case (port_q)
                    P_I:     i_rdata_d = 32'h0;
                    P_D:     d_rdata_d = 16'h0;
                    default: x_rdata_d = 16'h0;
                endcase
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= P_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            inst_q    <= 1'b0;
            starve_q  <= '0;
            guard_q   <= '0;
            rdy_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            x_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            inst_q    <= inst_d;
            starve_q  <= starve_d;
            guard_q   <= guard_d;
            rdy_q     <= rdy_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            x_rdata_q <= x_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign m_read_req         = (state_q == REQ) && !we_q;
    assign m_write_req        = (state_q == REQ) && we_q;
    assign m_addr             = addr_q;
    assign m_wdata            = wdata_q;
    assign m_instruction_mode = inst_q;
    assign i_ready            = rdy_q[P_I];
    assign d_ready            = rdy_q[P_D];
    assign x_ready            = rdy_q[P_X];
    assign i_rdata            = i_rdata_q;
    assign d_rdata            = d_rdata_q;
    assign x_rdata            = x_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a cycle-counting SDRAM controller model.
module tb_sdram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_rd_req, d_wr_req, x_req, x_we;
    logic [22:0] i_addr, d_addr, x_addr;
    logic [15:0] d_wdata, x_wdata;
    logic [31:0] i_rdata;
    logic [15:0] d_rdata, x_rdata;
    logic        i_ready, d_ready, x_ready;
    logic [22:0] m_addr;
    logic [15:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_read_req, m_write_req, m_instruction_mode;
    logic        m_busy, m_cack, m_read_ready, err;

    sdram_arbiter #(.STARVE_MAX(8), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_rdata(x_rdata), .x_ready(x_ready),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_read_req(m_read_req), .m_write_req(m_write_req),
        .m_instruction_mode(m_instruction_mode), .m_busy(m_busy),
        .m_cack(m_cack), .m_read_ready(m_read_ready), .err(err)
    );

    int n_chk = 0, n_fail = 0;

    // Controller model state, sampled 1 time unit after each rising edge.
    int          cyc = 0, mdl_phase = 0, mdl_cnt = 0, req_cycles = 0;
    int          req_start = 0, cack_cyc = 0, rr_cyc = 0;
    int          i_rc = 0, d_rc = 0, x_rc = 0;
    int          i_cnt = 0, d_cnt = 0, x_cnt = 0;
    int          cack_dly = 2, data_dly = 6;
    logic        mdl_fixed = 1'b1, mdl_nodata = 1'b0, keep_di = 1'b0;
    logic [31:0] mdl_data = 32'h0;
    logic [22:0] mdl_addr = '0;
    logic [15:0] mdl_wdata = '0;
    logic        mdl_we = 1'b0, mdl_imode = 1'b0;
    byte         ord[$];

    initial begin
        m_cack = 1'b0; m_read_ready = 1'b0; m_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            m_cack = 1'b0; m_read_ready = 1'b0;
            if (i_ready) begin i_cnt++; i_rc = cyc; ord.push_back("I"); if (!keep_di) i_req = 1'b0; end
            if (d_ready) begin
                d_cnt++; d_rc = cyc; ord.push_back("D");
                if (!keep_di) begin d_rd_req = 1'b0; d_wr_req = 1'b0; end
            end
            if (x_ready) begin x_cnt++; x_rc = cyc; ord.push_back("X"); x_req = 1'b0; end
            if (mdl_phase == 0) begin
                if (m_read_req || m_write_req) begin
                    if (mdl_cnt == 0) begin
                        req_start = cyc; mdl_addr = m_addr; mdl_wdata = m_wdata;
                        mdl_we = m_write_req; mdl_imode = m_instruction_mode;
                    end
                    mdl_cnt++; req_cycles = mdl_cnt;
                    if (mdl_cnt == cack_dly) begin
                        m_cack = 1'b1; cack_cyc = cyc; mdl_cnt = 0;
                        if (m_read_req && !mdl_nodata) mdl_phase = 1;
                    end
                end
            end else begin
                mdl_cnt++;
                if (mdl_cnt == data_dly) begin
                    m_read_ready = 1'b1; rr_cyc = cyc; mdl_cnt = 0; mdl_phase = 0;
                    m_rdata = mdl_fixed ? mdl_data : {~mdl_addr[15:0], mdl_addr[15:0]};
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({m_read_req, m_write_req, m_instruction_mode} !== 3'b000) begin
            n_fail++; $display("FAIL reset_reqs got %b want 000", {m_read_req, m_write_req, m_instruction_mode}); end
        n_chk++; if ({m_addr, m_wdata} !== 39'h0) begin
            n_fail++; $display("FAIL reset_addr_data got %h want 0", {m_addr, m_wdata}); end
        n_chk++; if ({i_ready, d_ready, x_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready got %b want 000", {i_ready, d_ready, x_ready}); end
        n_chk++; if ({i_rdata, d_rdata, x_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h want 0", {i_rdata, d_rdata, x_rdata}); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        int i0 = i_cnt;
        mdl_fixed = 1'b1; mdl_data = 32'hDEADBEEF; cack_dly = 2; data_dly = 6;
        i_addr = 23'h000100; i_req = 1'b1;
        @(negedge clk);
        n_chk++; if (m_read_req !== 1'b1) begin n_fail++; $display("FAIL i_latency m_read_req=%b want 1", m_read_req); end
        n_chk++; if (m_instruction_mode !== 1'b1) begin n_fail++; $display("FAIL i_imode got %b want 1", m_instruction_mode); end
        n_chk++; if (m_addr !== 23'h000100) begin n_fail++; $display("FAIL i_addr got %h want 000100", m_addr); end
        for (int k = 0; k < 60 && i_cnt == i0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_chk++; if (i_cnt !== i0 + 1) begin n_fail++; $display("FAIL i_ready_pulses got %0d want 1", i_cnt - i0); end
        n_chk++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL i_rdata got %h want deadbeef", i_rdata); end
        n_chk++; if (i_rc - rr_cyc !== 1) begin n_fail++; $display("FAIL i_ready_lag got %0d want 1", i_rc - rr_cyc); end
    endtask

    task automatic test_d_write();
        int d0 = d_cnt, i0 = i_cnt;
        cack_dly = 3; mdl_fixed = 1'b1; mdl_data = 32'h0BADF00D;
        d_addr = 23'h400010; d_wdata = 16'h1234; d_wr_req = 1'b1;
        i_addr = 23'h000200; i_req = 1'b1;
        for (int k = 0; k < 60 && d_cnt == d0; k++) @(negedge clk);
        n_chk++; if ({mdl_we, mdl_addr, mdl_wdata} !== {1'b1, 23'h400010, 16'h1234}) begin
            n_fail++; $display("FAIL d_wr_cmd got we=%b a=%h w=%h want 1/400010/1234", mdl_we, mdl_addr, mdl_wdata); end
        n_chk++; if (req_cycles !== 3) begin n_fail++; $display("FAIL d_wr_hold got %0d want 3", req_cycles); end
        n_chk++; if (d_rc - cack_cyc !== 1) begin n_fail++; $display("FAIL d_wr_ready_lag got %0d want 1", d_rc - cack_cyc); end
        for (int k = 0; k < 60 && i_cnt == i0; k++) @(negedge clk);
        n_chk++; if (req_start - d_rc !== 3) begin n_fail++; $display("FAIL guard_gap got %0d want 3", req_start - d_rc); end
        n_chk++; if (i_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL d_wr_then_i got %h want 0badf00d", i_rdata); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_priority();
        int i0 = i_cnt, d0 = d_cnt, x0 = x_cnt;
        cack_dly = 1; data_dly = 4; mdl_fixed = 1'b0; ord.delete();
        i_addr = 23'h22; d_addr = 23'h11; x_addr = 23'h33; x_we = 1'b0;
        i_req = 1'b1; d_rd_req = 1'b1; x_req = 1'b1;
        for (int k = 0; k < 200 && !(i_cnt > i0 && d_cnt > d0 && x_cnt > x0); k++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_chk++; if ({ord[0], ord[1], ord[2]} !== "DIX") begin
            n_fail++; $display("FAIL prio_order got %s%s%s want DIX", ord[0], ord[1], ord[2]); end
        n_chk++; if ({i_cnt - i0, d_cnt - d0, x_cnt - x0} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL prio_pulses got i%0d d%0d x%0d want 1 each", i_cnt - i0, d_cnt - d0, x_cnt - x0); end
        n_chk++; if (d_rdata !== 16'h0011) begin n_fail++; $display("FAIL prio_d_rdata got %h want 0011", d_rdata); end
        n_chk++; if (i_rdata !== 32'hFFDD0022) begin n_fail++; $display("FAIL prio_i_rdata got %h want ffdd0022", i_rdata); end
        n_chk++; if (x_rdata !== 16'h0033) begin n_fail++; $display("FAIL prio_x_rdata got %h want 0033", x_rdata); end
    endtask

    task automatic test_starve();
        int x0 = x_cnt, xpos = -1;
        ord.delete(); keep_di = 1'b1;
        d_addr = 23'h50; i_addr = 23'h60; x_addr = 23'h70; x_we = 1'b0;
        d_rd_req = 1'b1; i_req = 1'b1; x_req = 1'b1;
        for (int k = 0; k < 600 && x_cnt == x0; k++) @(negedge clk);
        keep_di = 1'b0; d_rd_req = 1'b0; i_req = 1'b0;
        foreach (ord[k]) if (ord[k] == "X" && xpos < 0) xpos = k;
        n_chk++; if (xpos !== 8) begin n_fail++; $display("FAIL starve_x_slot got %0d want 8", xpos); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_busy();
        int x0 = x_cnt;
        cack_dly = 2; m_busy = 1'b1;
        x_addr = 23'h7; x_wdata = 16'hBEEF; x_we = 1'b1; x_req = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++; if ({m_write_req, m_read_req} !== 2'b00 || x_cnt != x0) begin
            n_fail++; $display("FAIL busy_hold got wr=%b rd=%b want 0 0", m_write_req, m_read_req); end
        m_busy = 1'b0;
        for (int k = 0; k < 60 && x_cnt == x0; k++) @(negedge clk);
        n_chk++; if ({x_cnt - x0, mdl_we, mdl_imode, mdl_wdata} !== {32'd1, 1'b1, 1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL busy_then_x got n=%0d we=%b im=%b w=%h want 1/1/0/beef", x_cnt - x0, mdl_we, mdl_imode, mdl_wdata); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int i0 = i_cnt;
        mdl_fixed = 1'b1; mdl_data = 32'h11112222; cack_dly = 1; data_dly = 10;
        i_addr = 23'h300; i_req = 1'b1;
        for (int k = 0; k < 30 && mdl_phase == 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if ({m_read_req, m_instruction_mode, m_addr, i_rdata} !== 57'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs got rd=%b im=%b a=%h r=%h want 0", m_read_req, m_instruction_mode, m_addr, i_rdata); end
        for (int k = 0; k < 30 && mdl_phase != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_chk++; if (i_cnt !== i0 || i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_late_rr got pulses=%0d r=%h want 0/0", i_cnt - i0, i_rdata); end
        data_dly = 6; mdl_data = 32'h12345678; i_addr = 23'h55; i_req = 1'b1;
        for (int k = 0; k < 60 && i_cnt == i0; k++) @(negedge clk);
        n_chk++; if (i_cnt !== i0 + 1 || i_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL rst_mid_recover got n=%0d r=%h want 1/12345678", i_cnt - i0, i_rdata); end
        repeat (4) @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = d_cnt, i0;
        mdl_nodata = 1'b1; cack_dly = 1;
        d_addr = 23'h44; d_rd_req = 1'b1;
        for (int k = 0; k < 80 && d_cnt == d0; k++) @(negedge clk);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", err); end
        n_chk++; if (d_rdata !== 16'h0 || d_cnt !== d0 + 1) begin
            n_fail++; $display("FAIL tmo_ready got n=%0d r=%h want 1/0000", d_cnt - d0, d_rdata); end
        n_chk++; if (d_rc - req_start !== 16) begin n_fail++; $display("FAIL tmo_cycles got %0d want 16", d_rc - req_start); end
        mdl_nodata = 1'b0; data_dly = 3; mdl_data = 32'hA0A0B0B0;
        i0 = i_cnt; i_addr = 23'h66; i_req = 1'b1;
        for (int k = 0; k < 60 && i_cnt == i0; k++) @(negedge clk);
        n_chk++; if (i_rdata !== 32'hA0A0B0B0 || err !== 1'b1) begin
            n_fail++; $display("FAIL tmo_recover got r=%h err=%b want a0a0b0b0/1", i_rdata, err); end
    endtask
`endif

    initial begin
        rst = 1'b1; m_busy = 1'b0;
        i_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0; x_req = 1'b0; x_we = 1'b0;
        i_addr = '0; d_addr = '0; x_addr = '0; d_wdata = '0; x_wdata = '0;
        test_reset();
        test_i_read();
        test_d_write();
        test_priority();
        test_starve();
        test_busy();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied got %b want 0", err); end
`endif
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
